serial_paralelo_n: RTL and testbench

SERIAL_PARALELO_N -- requirements
Module: serial_paralelo_n

---
 rtl/serial_paralelo_n.sv | 155 +++++++++++++++
 tb/tb_serial_paralelo_n.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_n.sv
// serial_paralelo_n: comma-aligned serial-to-parallel receiver.
// A bit-rate shift register hunts for the COMMA symbol, locks the word
// boundary on the first hit, and declares the link ACTIVE after COMMA_COUNT
// consecutive aligned commas. In ACTIVE every non-comma word is delivered on
// data_rx with a single-cycle valid_rx pulse on the edge of its last bit.
// Optional feature: define SP_LOSS_DETECT_EN to drop back to SEARCH after
// LOSS_WORDS consecutive non-comma words; otherwise ACTIVE holds until reset.
module serial_paralelo_n #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COMMA       = WIDTH'(8'hBC),
  parameter int               COMMA_COUNT = 4,
  parameter int               LOSS_WORDS  = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_rx,
  output logic             valid_rx,
  output logic             active,
  output logic [1:0]       sync_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int               CNT_W        = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       COMMA_TARGET = 4'(COMMA_COUNT);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("serial_paralelo_n: WIDTH must be in 4..32");
  end
  if (COMMA_COUNT < 1 || COMMA_COUNT > 15) begin : g_bad_comma_count
    $error("serial_paralelo_n: COMMA_COUNT must be in 1..15");
  end
  if (LOSS_WORDS < 2 || LOSS_WORDS > 255) begin : g_bad_loss_words
    $error("serial_paralelo_n: LOSS_WORDS must be in 2..255");
  end

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       comma_cnt;

`ifdef SP_LOSS_DETECT_EN
  localparam logic [7:0] LOSS_TARGET = 8'(LOSS_WORDS);
  logic [7:0] loss_cnt;
`endif

  // Word formed by the bit arriving on this edge and the WIDTH-1 before it.
  logic [WIDTH-1:0] candidate;
  logic             cand_is_comma;
  logic             at_boundary;

  assign candidate     = {sr[WIDTH-2:0], data_in};
  assign cand_is_comma = (candidate == COMMA);
  assign at_boundary   = (bit_cnt == LAST_BIT);

  // The state register itself is the encoded status output.
  assign sync_state = state;

  // Alignment FSM, word counters and registered outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      data_rx   <= '0;
      valid_rx  <= 1'b0;
      active    <= 1'b0;
`ifdef SP_LOSS_DETECT_EN
      loss_cnt  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // sees the pre-edge values of sr, bit_cnt and the counters, and a later
      // assignment in the same pass simply overrides an earlier default.
      sr       <= candidate;
      valid_rx <= 1'b0;
      bit_cnt  <= at_boundary ? '0 : bit_cnt + 1'b1;

      case (state)
        SEARCH: begin
`ifdef SP_LOSS_DETECT_EN
          loss_cnt <= '0;
`endif
          // Bit-level hunt: any comma fixes the boundary at this edge.
          if (cand_is_comma) begin
            bit_cnt   <= '0;
            comma_cnt <= 4'd1;
            if (COMMA_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end

        COUNT: begin
          // Only whole words on the locked boundary are judged here.
          if (at_boundary) begin
            if (cand_is_comma) begin
              if (comma_cnt != COMMA_TARGET) begin
                comma_cnt <= comma_cnt + 4'd1;
              end
              if (comma_cnt + 4'd1 >= COMMA_TARGET) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              comma_cnt <= '0;
              state     <= SEARCH;
            end
          end
        end

        ACTIVE: begin
          if (at_boundary) begin
            if (!cand_is_comma) begin
              data_rx  <= candidate;
              valid_rx <= 1'b1;
`ifdef SP_LOSS_DETECT_EN
              // The word that trips the limit is still delivered above.
              if (loss_cnt + 8'd1 >= LOSS_TARGET) begin
                loss_cnt  <= LOSS_TARGET;
                comma_cnt <= '0;
                state     <= SEARCH;
                active    <= 1'b0;
              end else begin
                loss_cnt <= loss_cnt + 8'd1;
              end
`endif
            end else begin
`ifdef SP_LOSS_DETECT_EN
              loss_cnt <= '0;
`endif
            end
          end
        end

        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_n.sv
// Testbench for serial_paralelo_n (WIDTH=8, COMMA=BC, COMMA_COUNT=4,
// LOSS_WORDS=16). A word-level reference model predicts the outputs after
// every clock edge; random data words are drawn with $urandom.
module tb_serial_paralelo_n;

  localparam logic [7:0] BC = 8'hBC;
  localparam int         CC = 4;
  localparam int         LW = 16;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_rx;
  logic       valid_rx;
  logic       active;
  logic [1:0] sync_state;

  serial_paralelo_n dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_rx    (data_rx),
    .valid_rx   (valid_rx),
    .active     (active),
    .sync_state (sync_state)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic       act;
    logic       vld;
    logic [7:0] dat;
    logic [1:0] st;
  } obs_t;

  int total = 0;
  int bad   = 0;

  // Pending stimulus bits and the expected outputs after each of their edges.
  bit   bits_q[$];
  obs_t exp_q[$];

  // Word-level receiver model: 0 searching, 1 counting commas, 2 active.
  int         m_mode;
  int         m_cnt;
  int         m_loss;
  logic [7:0] m_data;
  int         m_valids;

  int valid_seen;
  int valid_edges[$];

  function automatic obs_t model_now(input logic vld);
    return {(m_mode == 2), vld, m_data, 2'(m_mode)};
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_cnt    = 0;
    m_loss   = 0;
    m_data   = 8'h00;
    m_valids = 0;
  endtask

  task automatic push_junk(input int n);
    for (int i = 0; i < n; i++) begin
      bits_q.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(model_now(1'b0));
    end
  endtask

  // One aligned word: outputs hold for the first seven bits, then the
  // receiver rules apply to the complete word on its last bit.
  task automatic push_word(input logic [7:0] w);
    logic vld;
    for (int b = 7; b >= 1; b--) begin
      bits_q.push_back(w[b]);
      exp_q.push_back(model_now(1'b0));
    end
    vld = 1'b0;
    case (m_mode)
      0: if (w == BC) begin
           m_cnt  = 1;
           m_mode = (CC == 1) ? 2 : 1;
           m_loss = 0;
         end
      1: if (w == BC) begin
           m_cnt = m_cnt + 1;
           if (m_cnt >= CC) begin
             m_mode = 2;
             m_loss = 0;
           end
         end else begin
           m_cnt  = 0;
           m_mode = 0;
         end
      default: if (w != BC) begin
           m_data   = w;
           vld      = 1'b1;
           m_valids = m_valids + 1;
`ifdef SP_LOSS_DETECT_EN
           m_loss = m_loss + 1;
           if (m_loss >= LW) begin
             m_mode = 0;
             m_cnt  = 0;
           end
`endif
         end else begin
           m_loss = 0;
         end
    endcase
    bits_q.push_back(w[0]);
    exp_q.push_back(model_now(vld));
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] w;
    do w = 8'($urandom); while (w == BC);
    return w;
  endfunction

  // Called at a falling edge: drive each bit, compare after its rising edge.
  task automatic run_stream(input string name);
    obs_t got;
    valid_seen = 0;
    valid_edges.delete();
    for (int i = 0; i < bits_q.size(); i++) begin
      data_in = bits_q[i];
      @(negedge clk_32f);
      got = {active, valid_rx, data_rx, sync_state};
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL %s edge %0d: got act=%b vld=%b data=%h st=%0d, want act=%b vld=%b data=%h st=%0d",
                 name, i, got.act, got.vld, got.dat, got.st,
                 exp_q[i].act, exp_q[i].vld, exp_q[i].dat, exp_q[i].st);
      end
      if (valid_rx === 1'b1) begin
        valid_seen++;
        valid_edges.push_back(i);
      end
    end
    bits_q.delete();
    exp_q.delete();
  endtask

  task automatic check_count(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({active, valid_rx, data_rx, sync_state} !== 12'h000) begin
      bad++;
      $display("FAIL %s: got act=%b vld=%b data=%h st=%0d, want all zero",
               name, active, valid_rx, data_rx, sync_state);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = 1'b0;
    @(negedge clk_32f);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    data_in = 1'b0;
    #1;
    check_outputs_zero("reset_async");
    @(negedge clk_32f);
    check_outputs_zero("reset_held");
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_align();
    do_reset();
    push_junk(3);
    repeat (4) push_word(BC);
    push_word(8'hFF);
    push_word(8'h01);
    run_stream("align");
    check_count("align_valid_count", valid_seen, 2);
  endtask

  task automatic test_false_start();
    logic [7:0] w;
    do_reset();
    repeat (3) push_word(BC);
    push_word(8'h55);
    repeat (4) push_word(BC);
    push_word(8'hA7);
    run_stream("false_start");
    check_count("false_start_valid_count", valid_seen, 1);
    w = data_rx;
    check_count("false_start_data", int'(w), 32'hA7);
  endtask

  task automatic test_comma_in_active();
    do_reset();
    repeat (4) push_word(BC);
    push_word(8'h11);
    push_word(BC);
    push_word(8'h22);
    run_stream("comma_in_active");
    check_count("comma_in_active_valid_count", valid_seen, 2);
    if (valid_edges.size() >= 2) begin
      check_count("comma_in_active_spacing", valid_edges[1] - valid_edges[0], 16);
    end else begin
      check_count("comma_in_active_pulses_present", valid_edges.size(), 2);
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    repeat (4) push_word(BC);
    push_word(rand_data());
    push_junk(3);
    run_stream("pre_reset");
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_word_reset_async");
    @(posedge clk_32f);
    #1;
    check_outputs_zero("mid_word_reset_clocked");
    @(negedge clk_32f);
    reset = 1'b1;
    model_reset();
    repeat (3) push_word(BC);
    push_word(rand_data());
    push_word(BC);
    push_word(rand_data());
    repeat (4) push_word(BC);
    push_word(rand_data());
    run_stream("post_reset");
    check_count("post_reset_valid_count", valid_seen, 1);
  endtask

  task automatic test_loss();
    do_reset();
    repeat (4) push_word(BC);
    repeat (LW + 2) push_word(8'h3C);
    run_stream("loss");
`ifdef SP_LOSS_DETECT_EN
    check_count("loss_valid_count", valid_seen, LW);
    check_count("loss_active_after", int'(active), 0);
`else
    check_count("loss_valid_count", valid_seen, LW + 2);
    check_count("loss_active_after", int'(active), 1);
`endif
  endtask

  task automatic test_back_to_back_random();
    int since_bc;
    do_reset();
    push_junk(3);
    repeat (CC) push_word(BC);
    since_bc = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0 || since_bc >= 7) begin
        push_word(BC);
        since_bc = 0;
      end else begin
        push_word(rand_data());
        since_bc++;
      end
    end
    run_stream("random");
    check_count("random_valid_count", valid_seen, m_valids);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_align();
    test_false_start();
    test_comma_in_active();
    test_reset_mid_word();
    test_loss();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
